// File: rtl/ps2_host_tx_pkg.sv
// Shared types and constants for the PS/2 host-to-device transmitter.
package ps2_host_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQUEST,
    ST_SHIFT,
    ST_WAIT_RELEASE
  } state_t;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_RTS   = 2'd1;
  localparam logic [1:0] ERR_XFER  = 2'd2;
  localparam logic [1:0] ERR_NOACK = 2'd3;

  localparam int unsigned CNT_W = 20;

  // Bit presented for frame position idx: 0..7 data, 8 parity, 9+ stop (released).
  function automatic logic frame_bit(input logic [8:0] frame, input logic [3:0] idx);
    return (idx < 4'd9) ? frame[idx] : 1'b1;
  endfunction

endpackage

// File: rtl/ps2_host_tx_line_filter.sv
// Two-flop synchronizer plus glitch filter for one PS/2 pad.
module ps2_line_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic pad_async,
  output logic level
);
  import ps2_host_tx_pkg::*;

  localparam int unsigned CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(FILTER_LEN - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // Level follows the synchronized pad only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync  <= 2'b11;
      level <= 1'b1;
      cnt   <= '0;
    end else begin
      sync <= {sync[0], pad_async};
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        level <= sync[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host transmitter: request-to-send, device-clocked frame shift-out, ACK check.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES      = 6000,
  parameter int unsigned RTS_TIMEOUT_CYCLES  = 750000,
  parameter int unsigned XFER_TIMEOUT_CYCLES = 100000,
  parameter int unsigned FILTER_LEN          = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_async,
  input  logic       ps2_data_async,
  output logic       ps2_clk_drive_low,
  output logic       ps2_data_drive_low,
  output logic       rx_inhibit,
  output logic       tx_done,
  output logic       tx_error,
  output logic [1:0] tx_err_code
);
  import ps2_host_tx_pkg::*;

  localparam logic [CNT_W-1:0] INH_LAST  = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] RTS_LAST  = CNT_W'(RTS_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] XFER_LAST = CNT_W'(XFER_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t           state_q, state_d;
  logic [7:0]       data_q, data_d;
  logic             parity_q, parity_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clk_dl_q, clk_dl_d;
  logic             dat_dl_q, dat_dl_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [1:0]       code_q, code_d;
  logic             fail;
  logic [1:0]       fail_code;

  logic clk_f, dat_f, clk_f_prev, fall;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk       (clk),
    .reset     (reset),
    .pad_async (ps2_clk_async),
    .level     (clk_f)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filter (
    .clk       (clk),
    .reset     (reset),
    .pad_async (ps2_data_async),
    .level     (dat_f)
  );

  assign fall = clk_f_prev & ~clk_f;

  // State and datapath registers; reset releases both pads immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      data_q     <= '0;
      parity_q   <= 1'b0;
      bit_cnt_q  <= '0;
      cnt_q      <= '0;
      clk_dl_q   <= 1'b0;
      dat_dl_q   <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      code_q     <= ERR_NONE;
      clk_f_prev <= 1'b1;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      parity_q   <= parity_d;
      bit_cnt_q  <= bit_cnt_d;
      cnt_q      <= cnt_d;
      clk_dl_q   <= clk_dl_d;
      dat_dl_q   <= dat_dl_d;
      done_q     <= done_d;
      err_q      <= err_d;
      code_q     <= code_d;
      clk_f_prev <= clk_f;
    end
  end

  // Next-state logic; timeouts are tested before fall so they take priority.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    parity_d  = parity_q;
    bit_cnt_d = bit_cnt_q;
    cnt_d     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    clk_dl_d  = clk_dl_q;
    dat_dl_d  = dat_dl_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    code_d    = code_q;
    fail      = 1'b0;
    fail_code = ERR_NONE;

    case (state_q)
      ST_IDLE: begin
        clk_dl_d = 1'b0;
        dat_dl_d = 1'b0;
        if (tx_valid) begin
          data_d   = tx_data;
          parity_d = ~^tx_data;
          code_d   = ERR_NONE;
          cnt_d    = '0;
          clk_dl_d = 1'b1;
          state_d  = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        if (cnt_q >= INH_LAST) begin
          clk_dl_d  = 1'b0;
          dat_dl_d  = 1'b1;
          bit_cnt_d = '0;
          cnt_d     = '0;
          state_d   = ST_REQUEST;
        end
      end
      ST_REQUEST: begin
        if (cnt_q >= RTS_LAST) begin
          fail      = 1'b1;
          fail_code = ERR_RTS;
        end else if (fall) begin
          dat_dl_d  = ~data_q[0];
          bit_cnt_d = 4'd1;
          cnt_d     = '0;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cnt_q >= XFER_LAST) begin
          fail      = 1'b1;
          fail_code = ERR_XFER;
        end else if (fall) begin
          if (bit_cnt_q == 4'd10) begin
            // Transfer timer keeps running into WAIT_RELEASE.
            if (!dat_f) state_d = ST_WAIT_RELEASE;
            else begin
              fail      = 1'b1;
              fail_code = ERR_NOACK;
            end
          end else begin
            dat_dl_d  = ~frame_bit({parity_q, data_q}, bit_cnt_q);
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      ST_WAIT_RELEASE: begin
        if (cnt_q >= XFER_LAST) begin
          fail      = 1'b1;
          fail_code = ERR_XFER;
        end else if (clk_f && dat_f) begin
          clk_dl_d = 1'b0;
          dat_dl_d = 1'b0;
          done_d   = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: begin
        clk_dl_d = 1'b0;
        dat_dl_d = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase

    if (fail) begin
      clk_dl_d = 1'b0;
      dat_dl_d = 1'b0;
      err_d    = 1'b1;
      code_d   = fail_code;
      state_d  = ST_IDLE;
    end
  end

  assign tx_ready           = (state_q == ST_IDLE);
  assign rx_inhibit         = (state_q != ST_IDLE);
  assign ps2_clk_drive_low  = clk_dl_q;
  assign ps2_data_drive_low = dat_dl_q;
  assign tx_done            = done_q;
  assign tx_error           = err_q;
  assign tx_err_code        = code_q;

endmodule
